// File: rtl/rng_server_pkg.sv
// Shared definitions for the random-number server: LFSR geometry, taps,
// zero-seed substitute and the draw FSM states.
package rng_pkg;
    localparam int LFSR_W = 13;
    localparam int TAP_A  = 12;
    localparam int TAP_B  = 3;
    localparam int TAP_C  = 2;
    localparam int TAP_D  = 0;
    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 13'h000F;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
    endfunction
endpackage

// File: rtl/rng_server_lfsr13.sv
// 13-bit Fibonacci LFSR with step enable and a synchronous seed load that
// replaces an all-zero seed (the lock-up state) with a fixed nonzero value.
module lfsr13
    import rng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 13'h000F
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              step_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    output logic [LFSR_W-1:0] lfsr_o,
    output logic [LFSR_W-1:0] lfsr_nxt_o
);
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (load_val_i == '0) ? ZERO_SEED_SUB : load_val_i;
        end else if (step_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o     = lfsr_q;
    assign lfsr_nxt_o = lfsr_d;
endmodule

// File: rtl/rng_server.sv
// Round-robin random-number server: each draw latches a winner, advances the
// shared LFSR SHIFTS steps, then presents the value for one cycle with its grant.
module rng_server
    import rng_pkg::*;
#(
    parameter int                N_REQ  = 4,
    parameter int                SHIFTS = 13,
    parameter logic [LFSR_W-1:0] SEED   = 13'h000F
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req_i,
    input  logic              seed_load_i,
    input  logic [LFSR_W-1:0] seed_in_i,
    output logic [N_REQ-1:0]  gnt_o,
    output logic              valid_o,
    output logic [LFSR_W-1:0] rnd_o,
    output logic              busy_o
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 4;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              valid_q, valid_d;
    logic [LFSR_W-1:0] rnd_q, rnd_d;
    logic              lfsr_step_en, lfsr_load;
    logic [LFSR_W-1:0] lfsr_val, lfsr_nxt;
    logic [PTR_W-1:0]  rr_pick, rr_idx;
    logic              rr_found;

    lfsr13 #(.SEED(SEED)) u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .step_i     (lfsr_step_en),
        .load_i     (lfsr_load),
        .load_val_i (seed_in_i),
        .lfsr_o     (lfsr_val),
        .lfsr_nxt_o (lfsr_nxt)
    );

    // Round-robin search: start at ptr, wrap past N_REQ-1 to 0.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = ptr_q;
        rr_idx   = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (!rr_found && req_i[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
            rr_idx = (rr_idx == PTR_W'(N_REQ - 1)) ? '0 : rr_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!seed_load_i && rr_found) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(SHIFTS - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result registers load on entry to DONE so they are valid exactly during DONE.
    always_comb begin
        ptr_d        = ptr_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        lfsr_step_en = 1'b0;
        lfsr_load    = 1'b0;
        gnt_d        = '0;
        valid_d      = 1'b0;
        rnd_d        = '0;
        case (state_q)
            IDLE: begin
                if (seed_load_i) begin
                    lfsr_load = 1'b1;
                end else if (rr_found) begin
                    win_d = rr_pick;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                lfsr_step_en = 1'b1;
                cnt_d        = cnt_q + CNT_W'(1);
            end
            DONE: begin
                ptr_d = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
            end
            default: ;
        endcase
        if (state_d == DONE) begin
            valid_d = 1'b1;
            gnt_d   = N_REQ'(1) << win_q;
            rnd_d   = lfsr_nxt;
        end
    end

    assign gnt_o   = gnt_q;
    assign valid_o = valid_q;
    assign rnd_o   = rnd_q;
    assign busy_o  = (state_q != IDLE);
endmodule

// File: tb/tb_rng_server.sv
// Scoreboard bench for rng_server: a transaction model predicts grant and
// value for every draw; a monitor pops and compares whenever valid is seen.
module tb_rng_server;
    localparam int N  = 4;
    localparam int SH = 13;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_i;
    logic        seed_load_i;
    logic [12:0] seed_in_i;
    logic [3:0]  gnt_o;
    logic        valid_o;
    logic [12:0] rnd_o;
    logic        busy_o;

    always #5 clock = ~clock;

    rng_server #(.N_REQ(N), .SHIFTS(SH), .SEED(13'h000F)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_i       (req_i),
        .seed_load_i (seed_load_i),
        .seed_in_i   (seed_in_i),
        .gnt_o       (gnt_o),
        .valid_o     (valid_o),
        .rnd_o       (rnd_o),
        .busy_o      (busy_o)
    );

    typedef struct packed {
        logic [3:0]  gnt;
        logic [12:0] rnd;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [12:0] m_lfsr;
    int          m_ptr;
    logic [12:0] last_rnd = '0;
    logic [3:0]  last_gnt = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] step(input logic [12:0] v);
        return {v[11:0], v[12] ^ v[3] ^ v[2] ^ v[0]};
    endfunction

    always @(negedge clock) begin
        if (valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("gnt", {28'd0, gnt_o}, {28'd0, mon_e.gnt});
                check("rnd", {19'd0, rnd_o}, {19'd0, mon_e.rnd});
            end
            last_rnd = rnd_o;
            last_gnt = gnt_o;
        end
    end

    // Drive a request pattern and push the model's prediction for the draw it starts.
    task automatic start_draw(input logic [3:0] r);
        int   w;
        exp_t e;
        req_i = r;
        w = -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (w < 0 && r[k]) w = k;
        end
        if (w >= 0) begin
            for (int s = 0; s < SH; s++) m_lfsr = step(m_lfsr);
            e.gnt = 4'(1 << w);
            e.rnd = m_lfsr;
            sb.push_back(e);
            m_ptr = (w + 1) % N;
        end
    endtask

    // mode 1: drop req after the sampling cycle and pulse seed_load mid-SHIFT.
    task automatic wait_done(input int exp_lat, input int mode);
        int cycles;
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
            if (cycles == exp_lat - SH) begin
                check("busy_shift", {31'd0, busy_o}, 32'd1);
                if (mode == 1) req_i = '0;
            end
            if (mode == 1 && cycles == 5) begin
                seed_load_i = 1'b1;
                seed_in_i   = 13'h1234;
            end
            if (mode == 1 && cycles == 6) seed_load_i = 1'b0;
        end while (valid_o !== 1'b1 && cycles < 60);
        check("latency", cycles, exp_lat);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_lfsr = 13'h000F;
        m_ptr  = 0;
        sb.delete();
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        req_i       = '0;
        seed_load_i = 1'b0;
        seed_in_i   = '0;
        m_lfsr      = 13'h000F;
        m_ptr       = 0;
        repeat (3) @(negedge clock);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_gnt",   {28'd0, gnt_o},   32'd0);
        check("rst_rnd",   {19'd0, rnd_o},   32'd0);
        check("rst_busy",  {31'd0, busy_o},  32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single draw from requester 0 out of reset.
        start_draw(4'b0001);
        wait_done(SH + 1, 0);
        check("first_rnd", {19'd0, last_rnd}, 32'h1FF4);
        check("first_gnt", {28'd0, last_gnt}, 32'b0001);
        req_i = '0;
        @(negedge clock);
        check("busy_after_done", {31'd0, busy_o}, 32'd0);
        check("valid_one_cycle", {31'd0, valid_o}, 32'd0);

        // All requesters held: rotate 0,1,2,3,0 one draw per SH+2 cycles.
        pulse_reset();
        start_draw(4'b1111);
        wait_done(SH + 1, 0);
        for (int d = 0; d < 4; d++) begin
            start_draw(4'b1111);
            wait_done(SH + 2, 0);
        end
        check("rr_wrap_gnt", {28'd0, last_gnt}, 32'b0001);
        req_i = '0;
        @(negedge clock);

        // Zero seed is substituted; explicit 000F gives the same draw.
        seed_load_i = 1'b1;
        seed_in_i   = 13'h0000;
        @(negedge clock);
        seed_load_i = 1'b0;
        m_lfsr = 13'h000F;
        start_draw(4'b0001);
        wait_done(SH + 1, 0);
        check("seed0_rnd", {19'd0, last_rnd}, 32'h1FF4);
        req_i = '0;
        @(negedge clock);
        seed_load_i = 1'b1;
        seed_in_i   = 13'h000F;
        @(negedge clock);
        seed_load_i = 1'b0;
        m_lfsr = 13'h000F;
        start_draw(4'b0001);
        wait_done(SH + 1, 0);
        check("seedF_rnd", {19'd0, last_rnd}, 32'h1FF4);
        req_i = '0;
        @(negedge clock);

        // One-cycle request pulse still completes; seed_load during SHIFT ignored.
        start_draw(4'b0100);
        wait_done(SH + 1, 1);
        check("pulse_gnt", {28'd0, last_gnt}, 32'b0100);
        @(negedge clock);
        start_draw(4'b0001);
        wait_done(SH + 1, 0);
        req_i = '0;
        @(negedge clock);

        // Reset in the sixth SHIFT cycle aborts the draw.
        start_draw(4'b0001);
        repeat (6) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_valid", {31'd0, valid_o}, 32'd0);
        check("abort_gnt",   {28'd0, gnt_o},   32'd0);
        check("abort_rnd",   {19'd0, rnd_o},   32'd0);
        check("abort_busy",  {31'd0, busy_o},  32'd0);
        void'(sb.pop_back());
        m_lfsr = 13'h000F;
        m_ptr  = 0;
        req_i  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        start_draw(4'b1111);
        wait_done(SH + 1, 0);
        check("post_abort_rnd", {19'd0, last_rnd}, 32'h1FF4);
        check("post_abort_gnt", {28'd0, last_gnt}, 32'b0001);
        req_i = '0;
        repeat (3) @(negedge clock);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rng_server.md
# rng_server

Shared random-number server for the game logic. It owns one 13-bit Fibonacci LFSR and hands out decorrelated draws to up to `N_REQ` requesters, such as spawn position, enemy choice and colour pick. Requesters are served round-robin. Each draw advances the LFSR `SHIFTS` steps before the value is delivered, so consecutive draws never share bits.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `SHIFTS`, 13: LFSR steps per draw, 1..15.
- `SEED`, 13'h000F: reset value of the LFSR; must be nonzero.

- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `req`  in  N_REQ  per-requester draw request, level.
- `seed_load`  in  1  load `seed_in` into the LFSR.
- `seed_in`  in  13  new seed value.
- `gnt`  out  N_REQ  one-hot; marks the requester served this cycle.
- `valid`  out  1  `rnd` is valid for the requester flagged in `gnt`.
- `rnd`  out  13  drawn value.
- `busy`  out  1  a draw is in progress (state is not IDLE).

## Operation
- LFSR step: `lfsr <= {lfsr[11:0], lfsr[12]^lfsr[3]^lfsr[2]^lfsr[0]}`. The LFSR steps only in the SHIFT state; it holds in every other state.
- FSM states are IDLE, SHIFT and DONE.
- **IDLE**, in priority order:
  - If `seed_load` is high: load `lfsr <= (seed_in==0) ? 13'h000F : seed_in`. No arbitration happens this cycle; stay in IDLE.
  - Else if `req != 0`: latch the round-robin winner, clear `cnt`, go to SHIFT.
- **SHIFT**:
  - Step the LFSR every cycle and increment `cnt` every cycle.
  - When `cnt == SHIFTS-1`, go to DONE.
- **DONE**: drive `valid=1`, `gnt`=latched winner and `rnd=lfsr`. Advance the pointer to `(winner+1) mod N_REQ`, then go to IDLE.
- **Round-robin**: search starts at `ptr` and wraps to 0; the first requester found with `req` high wins. `ptr` resets to 0.
- The winner is latched when the draw starts. If the winner drops `req` during SHIFT, the draw still completes and `gnt` still pulses.
- `seed_load` outside IDLE is ignored; it is not queued.
- Outside DONE: `gnt=0`, `valid=0`, `rnd=0`.

## Timing
- Reset values:
  - Outputs: `gnt=0`, `valid=0`, `rnd=0`, `busy=0`.
  - Internal: `lfsr=SEED`, `ptr=0`, `cnt=0`, state IDLE.
- `gnt`, `valid` and `rnd` are registered outputs. `busy` is decoded from the state.
- Cycle numbering: `req` is sampled in IDLE at cycle t, SHIFT occupies t+1 … t+SHIFTS, and DONE is cycle t+SHIFTS+1.
  - Latency = `SHIFTS+1` cycles.
  - `valid` is high for exactly 1 cycle.
- The earliest next draw starts in the IDLE cycle t+SHIFTS+2. Peak throughput is one draw per `SHIFTS+2` cycles.
- A requester holds `req` until it sees its `gnt` bit, and drops it the cycle after. If `req` is still high in the following IDLE cycle, that counts as a new request.
- Asserting `reset` mid-draw aborts the draw immediately: no `valid` is produced and the LFSR returns to `SEED`.

## Structure
- Package `rng_pkg` holds:
  - `LFSR_W=13`.
  - The tap constants.
  - `ZERO_SEED_SUB=13'h000F`.
  - The state enum `{IDLE, SHIFT, DONE}`.
- Sub-module `lfsr13` contains the register, the step enable and the synchronous load with zero-substitution. `rng_server` instantiates it and contains the FSM, the counter and the round-robin arbiter.

## Test plan
- Reset, then `req=4'b0001` held until grant → `busy` goes high the next cycle; `valid` and `gnt=4'b0001` appear 14 cycles after the sampling edge, with `rnd=13'h1FF4`; `busy` drops after DONE.
- `req=4'b1111` held continuously → grants arrive in the order 0001, 0010, 0100, 1000, 0001, one every 15 cycles. Each `rnd` must match the software model: 13 LFSR steps after the previous value.
- `seed_load=1` with `seed_in=0` in IDLE, then one draw → LFSR loads 13'h000F and `rnd=13'h1FF4`. Then repeat with `seed_in=13'h000F` → identical result.
- Requester 2 pulses `req` for only the sampling cycle → the draw still completes and `gnt=4'b0100` pulses. `seed_load` asserted during SHIFT → ignored; `rnd` is unchanged from the model.
- `reset` asserted at SHIFT cycle 6 → outputs return to 0 on the same edge, with no `valid`. The next draw yields 13'h1FF4 to requester 0 (`ptr=0`).
